// File: rtl/lc3_pkg.sv
// lc3_pkg: shared opcodes, state encodings, select encodings and the control word for lc3_ctrl.
// LC3_CTRL_LDR_STR_EN enables the LDR/STR dispatch.
package lc3_pkg;
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [4:0] S_FETCH1  = 5'd0;
    localparam logic [4:0] S_FETCH2  = 5'd1;
    localparam logic [4:0] S_FETCH3  = 5'd2;
    localparam logic [4:0] S_DECODE  = 5'd3;
    localparam logic [4:0] S_ALU     = 5'd4;
    localparam logic [4:0] S_BR_TEST = 5'd5;
    localparam logic [4:0] S_BR_TAKE = 5'd6;
    localparam logic [4:0] S_JMP     = 5'd7;
    localparam logic [4:0] S_LEA     = 5'd8;
    localparam logic [4:0] S_LD_A    = 5'd9;
    localparam logic [4:0] S_LD_M    = 5'd10;
    localparam logic [4:0] S_LD_W    = 5'd11;
    localparam logic [4:0] S_ST_A    = 5'd12;
    localparam logic [4:0] S_ST_D    = 5'd13;
    localparam logic [4:0] S_ST_M    = 5'd14;
    localparam logic [4:0] S_ILL     = 5'd15;

    localparam logic [1:0] PC_INC   = 2'd0;
    localparam logic [1:0] PC_ADDR  = 2'd1;
    localparam logic [1:0] PC_BUS   = 2'd2;
    localparam logic [1:0] A2_ZERO  = 2'd0;
    localparam logic [1:0] A2_OFF6  = 2'd1;
    localparam logic [1:0] A2_OFF9  = 2'd2;
    localparam logic [1:0] A2_OFF11 = 2'd3;
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_AND   = 2'd1;
    localparam logic [1:0] ALU_NOT   = 2'd2;
    localparam logic [1:0] ALU_PASSA = 2'd3;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_reg;
        logic       ld_pc;
        logic       ld_cc;
        logic       ld_ben;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic       marmux;
        logic [1:0] aluk;
        logic       mio_en;
        logic       r_w;
        logic       illegal;
    } ctrl_t;

    function automatic logic [4:0] dispatch(input logic [3:0] op);
        case (op)
            OP_ADD, OP_AND, OP_NOT: dispatch = S_ALU;
            OP_BR:                  dispatch = S_BR_TEST;
            OP_JMP:                 dispatch = S_JMP;
            OP_LEA:                 dispatch = S_LEA;
            OP_LD:                  dispatch = S_LD_A;
            OP_ST:                  dispatch = S_ST_A;
`ifdef LC3_CTRL_LDR_STR_EN
            OP_LDR:                 dispatch = S_LD_A;
            OP_STR:                 dispatch = S_ST_A;
`endif
            default:                dispatch = S_ILL;
        endcase
    endfunction
endpackage

// File: rtl/lc3_ctrl_decode.sv
// lc3_ctrl_decode: combinational map from state and opcode to the datapath control word.
// LC3_CTRL_LDR_STR_EN selects BaseR+off6 addressing in the address states for LDR/STR.
module lc3_ctrl_decode
    import lc3_pkg::*;
(
    input  logic [4:0] state,
    input  logic [3:0] op,
    output ctrl_t      ctrl
);
    logic idx;
`ifdef LC3_CTRL_LDR_STR_EN
    assign idx = (op == OP_LDR) || (op == OP_STR);
`else
    assign idx = 1'b0;
`endif

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH1: begin
                ctrl.ld_mar  = 1'b1;
                ctrl.gate_pc = 1'b1;
                ctrl.ld_pc   = 1'b1;
                ctrl.pcmux   = PC_INC;
            end
            S_FETCH2, S_LD_M: begin
                ctrl.mio_en = 1'b1;
                ctrl.ld_mdr = 1'b1;
            end
            S_FETCH3: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_ir    = 1'b1;
            end
            S_DECODE: ctrl.ld_ben = 1'b1;
            S_ALU: begin
                ctrl.gate_alu = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                ctrl.aluk     = op == OP_AND ? ALU_AND : op == OP_NOT ? ALU_NOT : ALU_ADD;
            end
            S_BR_TAKE: begin
                ctrl.ld_pc    = 1'b1;
                ctrl.pcmux    = PC_ADDR;
                ctrl.addr2mux = A2_OFF9;
            end
            S_JMP: begin
                ctrl.ld_pc    = 1'b1;
                ctrl.pcmux    = PC_ADDR;
                ctrl.addr1mux = 1'b1;
                ctrl.addr2mux = A2_ZERO;
            end
            S_LEA: begin
                ctrl.gate_marmux = 1'b1;
                ctrl.marmux      = 1'b1;
                ctrl.addr2mux    = A2_OFF9;
                ctrl.ld_reg      = 1'b1;
            end
            S_LD_A, S_ST_A: begin
                ctrl.ld_mar      = 1'b1;
                ctrl.gate_marmux = 1'b1;
                ctrl.marmux      = 1'b1;
                ctrl.addr1mux    = idx;
                ctrl.addr2mux    = idx ? A2_OFF6 : A2_OFF9;
            end
            S_LD_W: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
            end
            S_ST_D: begin
                ctrl.gate_alu = 1'b1;
                ctrl.aluk     = ALU_PASSA;
                ctrl.ld_mdr   = 1'b1;
            end
            S_ST_M: begin
                ctrl.mio_en = 1'b1;
                ctrl.r_w    = 1'b1;
            end
            S_ILL: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/lc3_ctrl.sv
// lc3_ctrl: Moore microsequencer for the LC-3 datapath (state register and next-state logic).
// LC3_CTRL_LDR_STR_EN adds LDR/STR through the LD/ST sequences.
module lc3_ctrl
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        ben,
    input  logic        mem_r,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_reg,
    output logic        ld_pc,
    output logic        ld_cc,
    output logic        ld_ben,
    output logic        gate_pc,
    output logic        gate_mdr,
    output logic        gate_alu,
    output logic        gate_marmux,
    output logic [1:0]  pcmux,
    output logic        addr1mux,
    output logic [1:0]  addr2mux,
    output logic        marmux,
    output logic [1:0]  aluk,
    output logic        mio_en,
    output logic        r_w,
    output logic        illegal,
    output logic [4:0]  state
);
    logic [4:0] state_q, state_d;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign unused_ir = ^ir[11:0];

    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= S_FETCH1;
        else      state_q <= state_d;

    always_comb begin
        state_d = S_FETCH1;
        case (state_q)
            S_FETCH1:  state_d = S_FETCH2;
            S_FETCH2:  state_d = mem_r ? S_FETCH3 : S_FETCH2;
            S_FETCH3:  state_d = S_DECODE;
            S_DECODE:  state_d = dispatch(ir[15:12]);
            S_BR_TEST: state_d = ben ? S_BR_TAKE : S_FETCH1;
            S_LD_A:    state_d = S_LD_M;
            S_LD_M:    state_d = mem_r ? S_LD_W : S_LD_M;
            S_ST_A:    state_d = S_ST_D;
            S_ST_D:    state_d = S_ST_M;
            S_ST_M:    state_d = mem_r ? S_FETCH1 : S_ST_M;
            default:   state_d = S_FETCH1;
        endcase
    end

    lc3_ctrl_decode u_decode (
        .state (state_q),
        .op    (ir[15:12]),
        .ctrl  (ctrl)
    );

    // Outputs are forced low while reset is held, independent of the clock.
    assign {ld_mar, ld_mdr, ld_ir, ld_reg, ld_pc, ld_cc, ld_ben, gate_pc, gate_mdr, gate_alu,
            gate_marmux, pcmux, addr1mux, addr2mux, marmux, aluk, mio_en, r_w, illegal}
        = rst ? ctrl : '0;
    assign state = rst ? state_q : 5'd0;
endmodule

// File: tb/tb_lc3_ctrl.sv
// tb_lc3_ctrl: scoreboard bench for lc3_ctrl; per-cycle stimulus and expected words are queued per instruction.
module tb_lc3_ctrl;
    import lc3_pkg::*;

    logic        clk, rst, ben, mem_r;
    logic [15:0] ir;
    logic        ld_mar, ld_mdr, ld_ir, ld_reg, ld_pc, ld_cc, ld_ben;
    logic        gate_pc, gate_mdr, gate_alu, gate_marmux, addr1mux, marmux, mio_en, r_w, illegal;
    logic [1:0]  pcmux, addr2mux, aluk;
    logic [4:0]  state;

    lc3_ctrl dut (
        .clk(clk), .rst(rst), .ir(ir), .ben(ben), .mem_r(mem_r),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_reg(ld_reg), .ld_pc(ld_pc),
        .ld_cc(ld_cc), .ld_ben(ld_ben), .gate_pc(gate_pc), .gate_mdr(gate_mdr),
        .gate_alu(gate_alu), .gate_marmux(gate_marmux), .pcmux(pcmux), .addr1mux(addr1mux),
        .addr2mux(addr2mux), .marmux(marmux), .aluk(aluk), .mio_en(mio_en), .r_w(r_w),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [15:0] ir; logic b; logic mr; } stim_t;
    typedef struct { string tag; logic [26:0] w; } exp_t;
    stim_t sq[$];
    exp_t  eq[$];
    int    n_chk = 0, n_err = 0, cc_cnt = 0;
    logic [26:0] obs;

    assign obs = {state, ld_mar, ld_mdr, ld_ir, ld_reg, ld_pc, ld_cc, ld_ben, gate_pc, gate_mdr,
                  gate_alu, gate_marmux, pcmux, addr1mux, addr2mux, marmux, aluk, mio_en, r_w, illegal};

    task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected control word per state, written from the instruction descriptions.
    function automatic logic [21:0] exp_out(input logic [4:0] s, input logic [3:0] op);
        logic [6:0] ld;
        logic [3:0] g;
        logic [1:0] pm, a2, ak;
        logic       a1, mm, me, rw, il, idx;
        {ld, g, pm, a1, a2, mm, ak, me, rw, il} = '0;
        idx = (op == 4'b0110) || (op == 4'b0111);
        case (s)
            S_FETCH1:       begin ld = 7'b1000100; g = 4'b1000; end
            S_FETCH2:       begin ld = 7'b0100000; me = 1'b1; end
            S_FETCH3:       begin ld = 7'b0010000; g = 4'b0100; end
            S_DECODE:       ld = 7'b0000001;
            S_ALU:          begin ld = 7'b0001010; g = 4'b0010; ak = op == 4'b0101 ? 2'd1 : op == 4'b1001 ? 2'd2 : 2'd0; end
            S_BR_TAKE:      begin ld = 7'b0000100; pm = 2'd1; a2 = 2'd2; end
            S_JMP:          begin ld = 7'b0000100; pm = 2'd1; a1 = 1'b1; end
            S_LEA:          begin ld = 7'b0001000; g = 4'b0001; mm = 1'b1; a2 = 2'd2; end
            S_LD_A, S_ST_A: begin ld = 7'b1000000; g = 4'b0001; mm = 1'b1; a1 = idx; a2 = idx ? 2'd1 : 2'd2; end
            S_LD_M:         begin ld = 7'b0100000; me = 1'b1; end
            S_LD_W:         begin ld = 7'b0001010; g = 4'b0100; end
            S_ST_D:         begin ld = 7'b0100000; g = 4'b0010; ak = 2'd3; end
            S_ST_M:         begin me = 1'b1; rw = 1'b1; end
            S_ILL:          il = 1'b1;
            default:        ;
        endcase
        return {ld, g, pm, a1, a2, mm, ak, me, rw, il};
    endfunction

    task automatic emit(input string tag, input logic [4:0] s, input logic [15:0] i, input logic b, input logic mr);
        sq.push_back('{ir: i, b: b, mr: mr});
        eq.push_back('{tag: $sformatf("%s/s%0d", tag, s), w: {s, exp_out(s, i[15:12])}});
    endtask

    task automatic add_instr(input string t, input logic [15:0] i, input int fw, input int mw, input logic bt);
        logic [3:0] op;
        op = i[15:12];
        emit(t, S_FETCH1, i, 1'b0, 1'b1);
        repeat (fw) emit(t, S_FETCH2, i, 1'b0, 1'b0);
        emit(t, S_FETCH2, i, 1'b0, 1'b1);
        emit(t, S_FETCH3, i, 1'b0, 1'b1);
        // ben in DECODE is the inverse of the BR_TEST value, so sampling one cycle early shows up.
        emit(t, S_DECODE, i, op == 4'b0000 ? ~bt : 1'b0, 1'b1);
        case (op)
            4'b0001, 4'b0101, 4'b1001: emit(t, S_ALU, i, 1'b0, 1'b1);
            4'b0000: begin
                emit(t, S_BR_TEST, i, bt, 1'b1);
                if (bt) emit(t, S_BR_TAKE, i, bt, 1'b1);
            end
            4'b1100: emit(t, S_JMP, i, 1'b0, 1'b1);
            4'b1110: emit(t, S_LEA, i, 1'b0, 1'b1);
`ifdef LC3_CTRL_LDR_STR_EN
            4'b0010, 4'b0110: begin
`else
            4'b0010: begin
`endif
                emit(t, S_LD_A, i, 1'b0, 1'b1);
                repeat (mw) emit(t, S_LD_M, i, 1'b0, 1'b0);
                emit(t, S_LD_M, i, 1'b0, 1'b1);
                emit(t, S_LD_W, i, 1'b0, 1'b1);
            end
`ifdef LC3_CTRL_LDR_STR_EN
            4'b0011, 4'b0111: begin
`else
            4'b0011: begin
`endif
                emit(t, S_ST_A, i, 1'b0, 1'b1);
                emit(t, S_ST_D, i, 1'b0, 1'b1);
                repeat (mw) emit(t, S_ST_M, i, 1'b0, 1'b0);
                emit(t, S_ST_M, i, 1'b0, 1'b1);
            end
            default: emit(t, S_ILL, i, 1'b0, 1'b1);
        endcase
    endtask

    task automatic run();
        stim_t s;
        exp_t  e;
        cc_cnt = 0;
        while (sq.size() > 0) begin
            @(negedge clk);
            s = sq.pop_front();
            ir = s.ir; ben = s.b; mem_r = s.mr;
            #1;
            e = eq.pop_front();
            check(e.tag, obs, e.w);
            check("cc_and_ben", {26'd0, ld_cc & ld_ben}, 27'd0);
            if (ld_cc) cc_cnt++;
        end
    endtask

    initial begin
        rst = 1'b0; ir = 16'h0; ben = 1'b0; mem_r = 1'b0;
        #12 check("reset_outputs", obs, 27'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        add_instr("add", 16'h1042, 0, 0, 1'b0);  run();
        add_instr("and", 16'h5042, 0, 0, 1'b0);  run();
        add_instr("not", 16'h903F, 1, 0, 1'b0);  run();
        add_instr("br_t", 16'h0E05, 0, 0, 1'b1); run();
        add_instr("br_n", 16'h0E05, 0, 0, 1'b0); run();
        add_instr("jmp", 16'hC1C0, 0, 0, 1'b0);  run();
        add_instr("lea", 16'hE203, 0, 0, 1'b0);  run();
        check("lea_cc", cc_cnt, 0);
        add_instr("ld", 16'h2205, 0, 3, 1'b0);   run();
        check("ld_cc_once", cc_cnt, 1);
        add_instr("st", 16'h3003, 0, 2, 1'b0);   run();
        check("st_cc_none", cc_cnt, 0);
        add_instr("ill_d", 16'hD000, 0, 0, 1'b0); run();
`ifdef LC3_CTRL_LDR_STR_EN
        add_instr("ldr", 16'h6283, 0, 1, 1'b0);  run();
        add_instr("str", 16'h7283, 0, 1, 1'b0);  run();
`else
        add_instr("ill_6", 16'h6283, 0, 0, 1'b0); run();
        add_instr("ill_7", 16'h7283, 0, 0, 1'b0); run();
`endif
        emit("pre_rst", S_FETCH1, 16'h1042, 1'b0, 1'b1);
        emit("pre_rst", S_FETCH2, 16'h1042, 1'b0, 1'b0);
        emit("pre_rst", S_FETCH2, 16'h1042, 1'b0, 1'b0);
        run();
        @(negedge clk);
        mem_r = 1'b0;
        #1 rst = 1'b0;
        #1 check("async_rst", obs, 27'd0);
        repeat (2) @(posedge clk);
        check("rst_held", obs, 27'd0);
        #2 rst = 1'b1;
        add_instr("post_rst", 16'h1042, 0, 0, 1'b0); run();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lc3_ctrl.md
# lc3_ctrl

Microsequenced control unit for the LC-3 datapath. It steps through fetch, decode and execute for a subset of the ISA. Every cycle it drives the datapath load enables, bus gates and mux selects, including `ld_cc` and `ld_ben` into the condition-code/BEN register. It reads `ir` and `ben` back from the datapath and handshakes with memory through `mem_r`.

## Interface
- No parameters.
- `clk` — input, 1 — system clock; all state changes on rising edge.
- `rst` — input, 1 — reset; asynchronous, active-low.
- `ir` — input, 16 — current instruction register contents.
- `ben` — input, 1 — registered branch-enable from the NZP block.
- `mem_r` — input, 1 — memory ready; the access completes in a cycle where `mem_r`=1.
- `ld_mar`, `ld_mdr`, `ld_ir`, `ld_reg`, `ld_pc`, `ld_cc`, `ld_ben` — output, 1 each — register load enables.
- `gate_pc`, `gate_mdr`, `gate_alu`, `gate_marmux` — output, 1 each — bus drivers; at most one is high per cycle.
- `pcmux` — output, 2 — PC source: 0 = PC+1, 1 = address adder, 2 = bus.
- `addr1mux` — output, 1 — address base: 0 = PC, 1 = SR1/BaseR.
- `addr2mux` — output, 2 — offset: 0 = zero, 1 = off6, 2 = off9, 3 = off11.
- `marmux` — output, 1 — 0 = zext(ir[7:0]), 1 = address adder.
- `aluk` — output, 2 — ALU op: 0 = ADD, 1 = AND, 2 = NOT, 3 = PASSA.
- `mio_en` — output, 1 — memory access enable.
- `r_w` — output, 1 — 1 = write, 0 = read.
- `illegal` — output, 1 — one-cycle pulse on an unsupported opcode.
- `state` — output, 5 — current state encoding, for debug.

## Operation
- Moore FSM. All outputs are a pure function of `state`. Every output is 0 while `rst`=0. The state register resets to FETCH1.
- FETCH1: `ld_mar`, `gate_pc`, `ld_pc`, `pcmux`=0.
- FETCH2: `mio_en`, `ld_mdr`. Stay in FETCH2 while `mem_r`=0; go to FETCH3 on `mem_r`=1.
- FETCH3: `gate_mdr`, `ld_ir`.
- DECODE: `ld_ben`. Branch on `ir[15:12]`.
- ALU (opcodes 0001 ADD, 0101 AND, 1001 NOT): `gate_alu`, `ld_reg`, `ld_cc`, `aluk` from the opcode. Next state FETCH1.
- BR (opcode 0000): BR_TEST takes no action. If `ben` go to BR_TAKE (`ld_pc`, `pcmux`=1, `addr1mux`=0, `addr2mux`=2), then FETCH1. Otherwise go straight to FETCH1.
- JMP (opcode 1100): `ld_pc`, `pcmux`=1, `addr1mux`=1, `addr2mux`=0. Next state FETCH1.
- LEA (opcode 1110): `gate_marmux`, `marmux`=1, `addr1mux`=0, `addr2mux`=2, `ld_reg`. CC is not changed. Next state FETCH1.
- LD (opcode 0010), three states:
  - LD_A: `ld_mar` from PC+off9 via `gate_marmux`.
  - LD_M: `mio_en`, `ld_mdr`; waits on `mem_r`.
  - LD_W: `gate_mdr`, `ld_reg`, `ld_cc`; then FETCH1.
- ST (opcode 0011), three states:
  - ST_A: MAR gets PC+off9.
  - ST_D: `gate_alu`, `aluk`=3, `ld_mdr`, `mio_en`=0.
  - ST_M: `mio_en`, `r_w`=1; waits on `mem_r`; then FETCH1.
- Any other opcode: state ILL asserts `illegal` for one cycle, then FETCH1. PC has already been incremented.

## Timing
- Instruction cycle counts with zero memory wait:
  - ALU, JMP, LEA, BR not-taken: 5 cycles.
  - BR taken: 6 cycles.
  - LD and ST: 7 cycles.
- Each cycle with `mem_r`=0 in a memory state adds one cycle. `mio_en` and `r_w` stay stable throughout the wait.
- `ld_ben` is high in DECODE, so `ben` is valid at BR_TEST, one cycle later. BR_TEST must not sample `ben` in DECODE.
- If `ld_cc` and `ld_ben` were high in the same cycle, BEN would use the old NZP values. The FSM never asserts both in one cycle.
- Reset asserted mid-instruction aborts immediately: outputs go to 0 and the FSM restarts at FETCH1 on the first edge after release.

## Configuration
- `LC3_CTRL_LDR_STR_EN` defined: opcodes 0110 LDR and 0111 STR follow the LD/ST sequences, with `addr1mux`=1 and `addr2mux`=1 in the address state.
- `LC3_CTRL_LDR_STR_EN` undefined: opcodes 0110 and 0111 go to ILL.

## Structure
- Shared package `lc3_pkg` holds:
  - opcode constants;
  - state encodings;
  - `pcmux`, `addr2mux` and `aluk` select encodings.
- Sub-module `lc3_ctrl_decode` is combinational and maps `state` plus `ir[15:12]` to the control word. `lc3_ctrl` holds the state register and next-state logic.

## Test plan
- Reset released, `mem_r`=1, memory returns ADD 0x1042 → `illegal` stays 0 throughout:
  - cycle 1 `ld_mar`, `ld_pc`, `gate_pc`;
  - cycle 3 `ld_ir`;
  - cycle 4 `ld_ben`;
  - cycle 5 `ld_reg`, `ld_cc`, `aluk`=0;
  - cycle 6 back in FETCH1.
- `ir`=0x0E05 (BRnzp):
  - `ben`=1 → BR_TAKE with `pcmux`=1, `addr2mux`=2;
  - repeat with `ben`=0 → FETCH1 directly after BR_TEST.
- LD with `mem_r` held 0 for 3 cycles in LD_M → `mio_en` and `ld_mdr` held for 4 cycles, `ld_cc` asserted exactly once in LD_W.
- ST 0x3003 → ST_D has `aluk`=3 and `ld_mdr`; ST_M has `mio_en`=1, `r_w`=1; `ld_cc` is never asserted.
- `ir` opcode 1101:
  - → one-cycle `illegal` pulse, then FETCH1;
  - with `LC3_CTRL_LDR_STR_EN` undefined, opcode 0110 also pulses `illegal`.
- `rst` pulled low during FETCH2 wait → all outputs 0 asynchronously; after release, `state`=FETCH1 and `ld_mar`=1.
